// File: rtl/rsff_pkg.sv
// Shared constants and helpers for the set/reset pipeline slice.
// Defaults here are the reference configuration; clog2 sizes the occupancy count.
package rsff_pkg;

  localparam int DEF_WIDTH          = 32'sd8;
  localparam int DEF_DEPTH          = 32'sd3;
  localparam bit DEF_SET_ACTIVE_LOW = 1'b1;

  function automatic int clog2(input int value);
    int p;
    int r;
    p = 32'sd1;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if (p < value) begin
        p = p + p;
        r = r + 32'sd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rsff_pipe_stage.sv
// One pipeline stage: data and valid registers with async reset, async set and load enable.
// Data only captures real words so an empty or flushed stage keeps its last value.
module rsff_pipe_stage #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             valid_nxt
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             valid_nxt_s;

  // Next valid state; the top also popcounts this to keep count registered.
  always_comb begin
    valid_nxt_s = valid_r;
    if (flush) begin
      valid_nxt_s = 1'b0;
    end else if (load) begin
      valid_nxt_s = in_valid;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // Stage registers; reset dominates set, set holds the stage full while asserted.
  always_ff @(posedge clk or posedge reset or posedge set) begin
    if (reset) begin
      data_r  <= RESET_VAL;
      valid_r <= 1'b0;
    end else if (set) begin
      data_r  <= SET_VAL;
      valid_r <= 1'b1;
    end else begin
      valid_r <= valid_nxt_s;
      if (!flush && load && in_valid) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign valid_nxt = valid_nxt_s;

endmodule

// File: rtl/rsff_pipe.sv
// Elastic pipeline of DEPTH stages with valid/ready handshakes, async reset/set and sync flush.
// in_ready is combinational through the ready chain; count tracks the number of valid stages.
module rsff_pipe
  import rsff_pkg::*;
#(
  parameter int               WIDTH          = DEF_WIDTH,
  parameter int               DEPTH          = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL      = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL        = {WIDTH{1'b1}},
  parameter bit               SET_ACTIVE_LOW = DEF_SET_ACTIVE_LOW
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         set,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [clog2(DEPTH+1)-1:0]    count
);

  localparam int CW = clog2(DEPTH + 1);

  logic             set_act_s;
  logic [WIDTH-1:0] data_s [DEPTH];
  logic [DEPTH-1:0] valid_s;
  logic [DEPTH-1:0] valid_nxt_s;
  logic [DEPTH-1:0] load_s;
  logic [CW-1:0]    count_nxt_s;
  logic [CW-1:0]    count_r;

  assign set_act_s = (SET_ACTIVE_LOW != 1'b0) ? ~set : set;

  // Ready chain from the output back: a stage loads when empty or when its successor frees up.
  always_comb begin
    logic free_s;
    load_s = {DEPTH{1'b0}};
    free_s = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      free_s    = ~valid_s[k] | free_s;
      load_s[k] = free_s;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src_data_s;
    logic             src_valid_s;

    if (k == 0) begin : g_head
      assign src_data_s  = in_data;
      assign src_valid_s = in_valid;
    end else begin : g_body
      assign src_data_s  = data_s[k-1];
      assign src_valid_s = valid_s[k-1];
    end

    rsff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL),
      .SET_VAL   (SET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .set       (set_act_s),
      .flush     (flush),
      .load      (load_s[k]),
      .in_data   (src_data_s),
      .in_valid  (src_valid_s),
      .data      (data_s[k]),
      .valid     (valid_s[k]),
      .valid_nxt (valid_nxt_s[k])
    );
  end

  // Population count of the next valid vector.
  always_comb begin
    count_nxt_s = {CW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      count_nxt_s = count_nxt_s + CW'(valid_nxt_s[k]);
    end
  end

  // Occupancy register follows the same async reset/set behaviour as the stages.
  always_ff @(posedge clk or posedge reset or posedge set_act_s) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (set_act_s) begin
      count_r <= CW'(DEPTH);
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign in_ready  = load_s[0];
  assign out_data  = data_s[DEPTH-1];
  assign out_valid = valid_s[DEPTH-1];
  assign count     = count_r;

endmodule

// File: tb/tb_rsff_pipe.sv
// Self-checking bench for rsff_pipe: directed scenarios plus randomized traffic against
// a slot-position model of the pipeline contents.
module tb_rsff_pipe;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       reset, set, flush;
  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic [1:0] count;

  rsff_pipe #(
    .WIDTH          (8),
    .DEPTH          (3),
    .RESET_VAL      (8'h00),
    .SET_VAL        (8'hFF),
    .SET_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .flush     (flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Model: words in arrival order, each with its slot position (D-1 is the output slot).
  typedef struct {
    logic [7:0] data;
    int         pos;
  } item_t;
  typedef item_t item_q_t[$];

  item_q_t    mq;
  logic [7:0] got[$];
  int         n_pass = 0;
  int         n_total = 0;
  bit         last_acc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One edge of movement: the head leaves if ready, then every word steps forward into a free slot.
  function automatic item_q_t model_advance(item_q_t qq, bit ordy);
    item_q_t r;
    r = qq;
    if (r.size() > 0 && r[0].pos == D - 1 && ordy) r.delete(0);
    for (int i = 0; i < r.size(); i++) begin
      if (r[i].pos < D - 1 && (i == 0 || r[i-1].pos > r[i].pos + 1)) r[i].pos = r[i].pos + 1;
    end
    return r;
  endfunction

  function automatic bit model_ready();
    item_q_t r;
    r = model_advance(mq, out_ready);
    return (r.size() == 0) || (r[r.size()-1].pos > 0);
  endfunction

  task automatic model_set();
    mq.delete();
    for (int i = 0; i < D; i++) mq.push_back('{8'hFF, D - 1 - i});
  endtask

  task automatic model_edge();
    bit acc;
    acc = 1'b0;
    if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && model_ready();
      mq = model_advance(mq, out_ready);
      if (acc) mq.push_back('{in_data, 0});
    end
    last_acc = acc;
  endtask

  task automatic compare();
    bit ev;
    ev = (mq.size() > 0) && (mq[0].pos == D - 1);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_data", out_data, mq[0].data);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, model_ready());
    if (out_valid && out_ready) got.push_back(out_data);
  endtask

  task automatic tick();
    #1;
    compare();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic send_word(logic [7:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      tick();
      done = last_acc;
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; set = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #2;
    chk("rst_count", count, 32'd0);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'h00);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 32'd1);

    // Streaming with out_ready high
    got.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send_word(8'(i));
      if (i == 3) chk("stream_count", count, 32'd3);
    end
    repeat (5) tick();
    chk("stream_n", got.size(), 32'd5);
    for (int i = 0; i < got.size(); i++) chk("stream_word", got[i], 32'(i + 1));

    // Backpressure
    got.delete();
    out_ready = 1'b0;
    send_word(8'hA1); send_word(8'hA2); send_word(8'hA3);
    in_valid = 1'b1; in_data = 8'hA4;
    tick(); tick();
    #1;
    chk("bp_in_ready", in_ready, 32'd0);
    chk("bp_count", count, 32'd3);
    out_ready = 1'b1;
    send_word(8'hA4);
    repeat (5) tick();
    chk("bp_n", got.size(), 32'd4);
    for (int i = 0; i < got.size(); i++) chk("bp_word", got[i], 32'hA1 + 32'(i));

    // Async set between edges
    out_ready = 1'b0;
    #2 set = 1'b0;
    #1;
    chk("set_out_data", out_data, 32'hFF);
    chk("set_out_valid", out_valid, 32'd1);
    chk("set_count", count, 32'd3);
    chk("set_in_ready", in_ready, 32'd0);
    model_set();
    set = 1'b1;
    got.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    chk("set_drain_n", got.size(), 32'd3);
    for (int i = 0; i < got.size(); i++) chk("set_drain_word", got[i], 32'hFF);

    // Async reset with a full pipeline, then with set also asserted
    out_ready = 1'b0;
    send_word(8'h11); send_word(8'h22); send_word(8'h33);
    chk("pre_rst_count", count, 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("arst_count", count, 32'd0);
    chk("arst_out_valid", out_valid, 32'd0);
    chk("arst_out_data", out_data, 32'h00);
    set = 1'b0;
    #1;
    chk("arst_set_count", count, 32'd0);
    chk("arst_set_out_valid", out_valid, 32'd0);
    chk("arst_set_out_data", out_data, 32'h00);
    set = 1'b1;
    reset = 1'b0;
    mq.delete();

    // Flush with two words held and a word offered on the flush edge
    send_word(8'hB1); send_word(8'hB2);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hC1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_count", count, 32'd0);
    got.delete();
    out_ready = 1'b1;
    repeat (5) tick();
    chk("flush_drain_n", got.size(), 32'd0);

    // Randomized traffic with occasional flush, set and reset pulses
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r == 0) begin
        #1 set = 1'b0;
        #1 set = 1'b1;
        model_set();
      end else if (r == 1) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        mq.delete();
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
